// File: rtl/frame_swap_controller.sv
// frame_swap_controller: double-buffer sequencer that swaps display banks
// only during vblank, with a frame-rate cap and missed-vblank statistics.
module frame_swap_controller #(
    parameter int FRAME_CNT_W = 16,
    parameter int MIN_VBLANKS = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   render_finish_sig,
    input  logic                   vga_vsync_sig,
    input  logic                   swap_enable,
    output logic                   render_restart_sig,
    output logic                   front_buffer_sel,
    output logic                   swap_pending,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic [7:0]             missed_vblank_count
);

    typedef enum logic [2:0] {
        IDLE,
        RESTART,
        RENDER,
        WAIT_VBLANK,
        SWAP
    } state_t;

    localparam logic [8:0] MIN_CNT = 9'(MIN_VBLANKS);
    localparam logic [7:0] MISS_TH = 8'(MIN_VBLANKS - 1);

    state_t     state;
    state_t     next_state;
    logic [2:0] vsync_sync;
    logic       vsync_evt;
    logic [7:0] vblank_cnt;
    logic       swap_ok;
    logic       miss_evt;
    logic       restart_d;
    logic       pending_d;

    // Two synchronizer stages plus one delay stage for falling-edge detect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_sync <= 3'b111;
        end else begin
            vsync_sync <= {vsync_sync[1:0], vga_vsync_sig};
        end
    end

    assign vsync_evt = vsync_sync[2] & ~vsync_sync[1];

    assign swap_ok = vsync_evt && swap_enable &&
                     (({1'b0, vblank_cnt} + 9'd1) >= MIN_CNT);

    assign miss_evt = vsync_evt &&
                      (state == RESTART || state == RENDER) &&
                      (vblank_cnt >= MISS_TH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // render_restart_sig is high exactly during the first RENDER cycle,
    // which is the cycle whose finish level may still be stale.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:        next_state = RESTART;
            RESTART:     next_state = RENDER;
            RENDER: begin
                if (!render_restart_sig && render_finish_sig) begin
                    next_state = WAIT_VBLANK;
                end
            end
            WAIT_VBLANK: begin
                if (swap_ok) begin
                    next_state = SWAP;
                end
            end
            SWAP:        next_state = RESTART;
            default:     next_state = IDLE;
        endcase
    end

    always_comb begin
        restart_d = (state == RESTART);
        pending_d = (next_state == WAIT_VBLANK);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            render_restart_sig  <= 1'b0;
            swap_pending        <= 1'b0;
            front_buffer_sel    <= 1'b0;
            frame_count         <= '0;
            missed_vblank_count <= 8'd0;
            vblank_cnt          <= 8'd0;
        end else begin
            render_restart_sig <= restart_d;
            swap_pending       <= pending_d;
            if (state == SWAP) begin
                front_buffer_sel <= ~front_buffer_sel;
                frame_count      <= frame_count + FRAME_CNT_W'(1);
            end
            if (state == SWAP) begin
                vblank_cnt <= 8'd0;
            end else if (vsync_evt && vblank_cnt != 8'hFF) begin
                vblank_cnt <= vblank_cnt + 8'd1;
            end
            if (miss_evt && missed_vblank_count != 8'hFF) begin
                missed_vblank_count <= missed_vblank_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_frame_swap_controller.sv
// tb_frame_swap_controller: two instances (MIN_VBLANKS 1 and 2) checked
// every cycle against a timestamp-based frame model, plus pinned literals.
module tb_frame_swap_controller;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        finish = 1'b0;
    logic        vsync = 1'b1;
    logic        en = 1'b1;

    logic        rst_a, fbs_a, pend_a;
    logic [15:0] fc_a;
    logic [7:0]  miss_a;
    logic        rst_b, fbs_b, pend_b;
    logic [15:0] fc_b;
    logic [7:0]  miss_b;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    frame_swap_controller #(.FRAME_CNT_W(16), .MIN_VBLANKS(1)) u_a (
        .clk                 (clk),
        .reset_n             (reset_n),
        .render_finish_sig   (finish),
        .vga_vsync_sig       (vsync),
        .swap_enable         (en),
        .render_restart_sig  (rst_a),
        .front_buffer_sel    (fbs_a),
        .swap_pending        (pend_a),
        .frame_count         (fc_a),
        .missed_vblank_count (miss_a)
    );

    frame_swap_controller #(.FRAME_CNT_W(16), .MIN_VBLANKS(2)) u_b (
        .clk                 (clk),
        .reset_n             (reset_n),
        .render_finish_sig   (finish),
        .vga_vsync_sig       (vsync),
        .swap_enable         (en),
        .render_restart_sig  (rst_b),
        .front_buffer_sel    (fbs_b),
        .swap_pending        (pend_b),
        .frame_count         (fc_b),
        .missed_vblank_count (miss_b)
    );

    // Model: each frame is described by timestamps (edge numbers) rather
    // than states: restart edge, whether the frame is done, swap edge.
    int          m_e    [2];
    int          m_r    [2];
    int          m_sw   [2];
    bit          m_done [2];
    logic [2:0]  m_h    [2];
    int          m_vb   [2];
    int          m_miss [2];
    logic [15:0] m_fc   [2];
    bit          m_fbs  [2];
    bit          m_rst  [2];
    bit          m_pend [2];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int i);
        m_e[i] = 0;
        m_r[i] = 2;
        m_sw[i] = -1;
        m_done[i] = 0;
        m_h[i] = 3'b111;
        m_vb[i] = 0;
        m_miss[i] = 0;
        m_fc[i] = 16'd0;
        m_fbs[i] = 0;
        m_rst[i] = 0;
        m_pend[i] = 0;
    endtask

    task automatic model_step(input int i, input int mn,
                              input bit fin, input bit ena, input bit vs);
        int e;
        bit evt;
        bit inflight;
        bit waiting;
        m_e[i] = m_e[i] + 1;
        e = m_e[i];
        // vsync level seen 3 and 2 edges ago: 1 then 0 = falling edge event
        evt = m_h[i][2] && !m_h[i][1];
        m_h[i] = {m_h[i][1:0], vs};
        if (m_sw[i] >= 0 && m_sw[i] == e - 1) begin
            m_fbs[i] = !m_fbs[i];
            m_fc[i] = m_fc[i] + 16'd1;
            m_vb[i] = 0;
            m_r[i] = e + 1;
            m_done[i] = 0;
            m_sw[i] = -1;
        end else begin
            inflight = (e >= m_r[i]) && !m_done[i];
            waiting = m_done[i] && (m_sw[i] < 0);
            if (evt) begin
                if (inflight && m_vb[i] >= mn - 1 && m_miss[i] < 255)
                    m_miss[i] = m_miss[i] + 1;
                if (waiting && ena && m_vb[i] + 1 >= mn)
                    m_sw[i] = e;
                if (m_vb[i] < 255)
                    m_vb[i] = m_vb[i] + 1;
            end
            if (inflight && fin && e >= m_r[i] + 2)
                m_done[i] = 1;
        end
        m_rst[i] = (e == m_r[i]);
        m_pend[i] = m_done[i] && (m_sw[i] < 0);
    endtask

    initial begin
        model_reset(0);
        model_reset(1);
    end

    always @(posedge clk) begin
        if (!reset_n) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0, 1, finish, en, vsync);
            model_step(1, 2, finish, en, vsync);
        end
    end

    always @(negedge clk) begin
        chk("a_restart", rst_a,  reset_n ? int'(m_rst[0])  : 0);
        chk("a_fbs",     fbs_a,  reset_n ? int'(m_fbs[0])  : 0);
        chk("a_pending", pend_a, reset_n ? int'(m_pend[0]) : 0);
        chk("a_fcount",  fc_a,   reset_n ? int'(m_fc[0])   : 0);
        chk("a_missed",  miss_a, reset_n ? m_miss[0]       : 0);
        chk("b_restart", rst_b,  reset_n ? int'(m_rst[1])  : 0);
        chk("b_fbs",     fbs_b,  reset_n ? int'(m_fbs[1])  : 0);
        chk("b_pending", pend_b, reset_n ? int'(m_pend[1]) : 0);
        chk("b_fcount",  fc_b,   reset_n ? int'(m_fc[1])   : 0);
        chk("b_missed",  miss_b, reset_n ? m_miss[1]       : 0);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic pulse();
        vsync = 1'b0;
        tick(3);
        vsync = 1'b1;
        tick(3);
    endtask

    int hold = 0;

    initial begin
        tick(3);
        reset_n = 1'b1;
        tick(1);
        chk("lit_a_restart_c1", rst_a, 0);
        chk("lit_b_restart_c1", rst_b, 0);
        tick(1);
        chk("lit_a_restart_c2", rst_a, 1);
        chk("lit_b_restart_c2", rst_b, 1);
        chk("lit_a_fbs_init", fbs_a, 0);
        tick(1);
        chk("lit_a_restart_c3", rst_a, 0);
        chk("lit_b_restart_c3", rst_b, 0);

        finish = 1'b1;
        tick(3);
        chk("lit_a_pending", pend_a, 1);
        chk("lit_b_pending", pend_b, 1);

        vsync = 1'b0;
        tick(3);
        chk("lit_a_fbs_pre", fbs_a, 0);
        chk("lit_a_pend_swap", pend_a, 0);
        chk("lit_b_pend_hold", pend_b, 1);
        tick(1);
        chk("lit_a_fbs_post", fbs_a, 1);
        chk("lit_a_fc1", fc_a, 1);
        tick(1);
        chk("lit_a_restart_swap", rst_a, 1);
        chk("lit_b_fbs_noswap", fbs_b, 0);
        chk("lit_b_fc0", fc_b, 0);
        vsync = 1'b1;
        tick(5);

        finish = 1'b0;
        vsync = 1'b0;
        tick(3);
        vsync = 1'b1;
        tick(6);
        chk("lit_a_fc2", fc_a, 2);
        chk("lit_a_fbs2", fbs_a, 0);
        chk("lit_b_fc1", fc_b, 1);
        chk("lit_b_fbs1", fbs_b, 1);

        repeat (3) pulse();
        tick(3);
        chk("lit_a_missed3", miss_a, 3);
        chk("lit_b_missed2", miss_b, 2);

        finish = 1'b1;
        tick(4);
        pulse();
        tick(4);
        chk("lit_a_fc3", fc_a, 3);
        chk("lit_b_fc2", fc_b, 2);

        en = 1'b0;
        repeat (5) pulse();
        chk("lit_a_fc_hold", fc_a, 3);
        chk("lit_b_fc_hold", fc_b, 2);
        chk("lit_a_fbs_hold", fbs_a, 1);
        chk("lit_a_pend_hold", pend_a, 1);
        en = 1'b1;
        pulse();
        tick(2);
        chk("lit_a_fc4", fc_a, 4);
        chk("lit_b_fc3", fc_b, 3);
        chk("lit_a_fbs4", fbs_a, 0);
        chk("lit_b_fbs3", fbs_b, 1);

        repeat (3) begin
            pulse();
            tick(2);
        end
        chk("lit_a_fc7", fc_a, 7);
        chk("lit_a_fbs7", fbs_a, 1);
        chk("lit_a_wait7", pend_a, 1);

        @(negedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("lit_a_rst_fbs", fbs_a, 0);
        chk("lit_a_rst_fc", fc_a, 0);
        chk("lit_a_rst_pend", pend_a, 0);
        chk("lit_a_rst_miss", miss_a, 0);
        chk("lit_b_rst_fc", fc_b, 0);
        tick(2);
        reset_n = 1'b1;
        tick(2);
        chk("lit_a_rerestart", rst_a, 1);
        chk("lit_b_rerestart", rst_b, 1);

        for (int c = 0; c < 1500; c++) begin
            if (hold == 0) begin
                vsync = ~vsync;
                hold = vsync ? int'($urandom_range(2, 10))
                             : int'($urandom_range(1, 4));
            end else begin
                hold--;
            end
            if ($urandom_range(0, 7) == 0) finish = ~finish;
            if ($urandom_range(0, 31) == 0) en = ~en;
            tick(1);
        end

        @(negedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("lit_b_rst2_fbs", fbs_b, 0);
        chk("lit_b_rst2_fc", fc_b, 0);
        tick(2);
        reset_n = 1'b1;
        tick(4);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
